// File: rtl/logic_gate_pkg.sv
// Shared op-codes and the bitwise gate evaluator for logic_gate_pipe.
// gate_eval works at GATE_MAX_W bits; callers zero-extend operands and truncate the result.
package logic_gate_pkg;

  localparam logic [2:0] OP_NOR    = 3'b000;
  localparam logic [2:0] OP_NAND   = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;
  localparam logic [2:0] OP_XNOR   = 3'b101;
  localparam logic [2:0] OP_NOT_A  = 3'b110;
  localparam logic [2:0] OP_PASS_A = 3'b111;

  localparam int unsigned GATE_MAX_W = 64;

  function automatic logic [GATE_MAX_W-1:0] gate_eval(
    input logic [2:0]            op,
    input logic [GATE_MAX_W-1:0] a,
    input logic [GATE_MAX_W-1:0] b
  );
    case (op)
      OP_NOR:    gate_eval = ~(a | b);
      OP_NAND:   gate_eval = ~(a & b);
      OP_AND:    gate_eval = a & b;
      OP_OR:     gate_eval = a | b;
      OP_XOR:    gate_eval = a ^ b;
      OP_XNOR:   gate_eval = ~(a ^ b);
      OP_NOT_A:  gate_eval = ~a;
      OP_PASS_A: gate_eval = a;
      default:   gate_eval = {GATE_MAX_W{1'b0}};
    endcase
  endfunction

endpackage

// File: rtl/logic_gate_pipe_fifo.sv
// result_fifo: synchronous FIFO holding gate results, asynchronous active-high reset.
// Pointers wrap naturally because DEPTH is a power of two.
module result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: registered WIDTH-bit 2-input gate with valid/ready handshake,
// DEPTH-entry result queue and accepted-operation counter. WIDTH must not exceed GATE_MAX_W.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  logic             full_s, empty_s;
  logic             accept_s, pop_s;
  logic [WIDTH-1:0] push_data_s, head_s;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  // in_ready depends only on queue state, never on out_ready in the same cycle
  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign accept_s  = in_valid && !full_s;
  assign pop_s     = out_ready && !empty_s;

  assign push_data_s = WIDTH'(gate_eval(in_op, GATE_MAX_W'(in_a), GATE_MAX_W'(in_b)));

  result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (accept_s),
    .pop_i   (pop_s),
    .data_i  (push_data_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign out_c    = empty_s ? {WIDTH{1'b0}} : head_s;
  assign out_zero = !empty_s && (head_s == {WIDTH{1'b0}});
  assign op_count = op_count_q;

  always_comb begin
    op_count_d = op_count_q;
    if (accept_s) begin
      op_count_d = op_count_q + CNT_W'(1);
    end else begin
      op_count_d = op_count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= {CNT_W{1'b0}};
    end else begin
      op_count_q <= op_count_d;
    end
  end

endmodule
